pipe_hazard_ctrl: RTL and testbench

//  Drives the write enables and bubble/flush controls of the 32-bit pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush control with load-use, branch squash, MDU freeze
module pipe_hazard_ctrl #(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_ex_memread,
    input  logic [4:0]       i_ex_rt,
    input  logic             i_ex_branch_taken,
    input  logic             i_ex_mdu_start,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_exmem_flush,
    output logic             o_mdu_done,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_stall_count
);
    localparam int MW = $clog2(MDU_CYCLES + 1);
    localparam logic [MW-1:0] MCNT_INIT = MW'(MDU_CYCLES - 1);

    typedef enum logic {S_RUN, S_MDU_BUSY} state_t;

    state_t           r_state;
    logic [MW-1:0]    r_mcnt;
    logic [CNT_W-1:0] r_stall_count;

    logic w_lu;
    logic w_mcnt_zero;

    assign w_lu = i_ex_memread && (i_ex_rt != 5'd0) &&
                  ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
    assign w_mcnt_zero = (r_mcnt == '0);

    always_comb begin
        o_pc_en       = 1'b0;
        o_ifid_en     = 1'b0;
        o_idex_en     = 1'b0;
        o_exmem_en    = 1'b0;
        o_memwb_en    = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_flush  = 1'b0;
        o_exmem_flush = 1'b0;
        o_mdu_done    = 1'b0;
        o_busy        = 1'b0;
        if (!i_rst) begin
            if (r_state == S_RUN) begin
                o_pc_en    = 1'b1;
                o_ifid_en  = 1'b1;
                o_idex_en  = 1'b1;
                o_exmem_en = 1'b1;
                o_memwb_en = 1'b1;
                // MDU start outranks branch, which outranks load-use
                if (i_ex_mdu_start) begin
                    o_pc_en       = 1'b0;
                    o_ifid_en     = 1'b0;
                    o_idex_en     = 1'b0;
                    o_exmem_flush = 1'b1;
                end else if (i_ex_branch_taken) begin
                    o_ifid_flush = 1'b1;
                    o_idex_flush = 1'b1;
                end else if (w_lu) begin
                    o_pc_en      = 1'b0;
                    o_ifid_en    = 1'b0;
                    o_idex_flush = 1'b1;
                end
            end else begin
                o_exmem_en    = 1'b1;
                o_exmem_flush = 1'b1;
                o_memwb_en    = 1'b1;
                o_busy        = 1'b1;
                // exit cycle: MDU op leaves EX while PC/IF still hold this edge
                if (w_mcnt_zero) begin
                    o_mdu_done = 1'b1;
                    o_idex_en  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_RUN;
            r_mcnt        <= '0;
            r_stall_count <= '0;
        end else begin
            if (!o_pc_en && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + 1'b1;
            case (r_state)
                S_RUN: begin
                    if (i_ex_mdu_start) begin
                        r_state <= S_MDU_BUSY;
                        r_mcnt  <= MCNT_INIT;
                    end
                end
                S_MDU_BUSY: begin
                    if (w_mcnt_zero)
                        r_state <= S_RUN;
                    else
                        r_mcnt <= r_mcnt - MW'(1);
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign o_stall_count = r_stall_count;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl (MDU_CYCLES=4, CNT_W=3)
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memread, ex_branch_taken, ex_mdu_start;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, mdu_done, busy;
    logic [2:0] stall_count;

    pipe_hazard_ctrl #(.MDU_CYCLES(4), .CNT_W(3)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
        .i_ex_memread(ex_memread), .i_ex_rt(ex_rt),
        .i_ex_branch_taken(ex_branch_taken), .i_ex_mdu_start(ex_mdu_start),
        .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_idex_en(idex_en),
        .o_exmem_en(exmem_en), .o_memwb_en(memwb_en),
        .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush), .o_exmem_flush(exmem_flush),
        .o_mdu_done(mdu_done), .o_busy(busy), .o_stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // ctrl bits: pc,ifid,idex,exmem,memwb, ifl,idfl,exfl, done,busy
    localparam logic [9:0] C_RST  = 10'b00000_000_00;
    localparam logic [9:0] C_RUN  = 10'b11111_000_00;
    localparam logic [9:0] C_LU   = 10'b00111_010_00;
    localparam logic [9:0] C_BR   = 10'b11111_110_00;
    localparam logic [9:0] C_MST  = 10'b00011_001_00;
    localparam logic [9:0] C_MBSY = 10'b00011_001_01;
    localparam logic [9:0] C_MEND = 10'b00111_001_11;

    typedef struct {
        logic [9:0] ctrl;
        logic [2:0] cnt;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic mr, input logic [4:0] ert,
                        input logic br, input logic mdu,
                        input logic [9:0] ec, input logic [2:0] ecnt, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_memread = mr; ex_rt = ert; ex_branch_taken = br; ex_mdu_start = mdu;
        e.ctrl = ec; e.cnt = ecnt; e.name = nm;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [9:0] act;
            e = sb.pop_front();
            act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, mdu_done, busy};
            checks++;
            if (act === e.ctrl && stall_count === e.cnt)
                passes++;
            else
                $display("FAIL %s: ctrl=%b cnt=%0d expected ctrl=%b cnt=%0d",
                         e.name, act, stall_count, e.ctrl, e.cnt);
        end
    end

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_rt = '0; ex_branch_taken = 1'b0; ex_mdu_start = 1'b0;
        repeat (2) @(posedge clk);

        step(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, "reset_a");
        step(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, "reset_b");
        step(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, "release");
        step(0, 5, 0, 0, 1, 5, 0, 0, C_LU,  0, "lu_rs");
        step(0, 5, 0, 0, 0, 5, 0, 0, C_RUN, 1, "lu_clear");
        step(0, 0, 0, 1, 1, 0, 0, 0, C_RUN, 1, "lu_rt_zero");
        step(0, 3, 7, 0, 1, 7, 0, 0, C_RUN, 1, "lu_rt_unused");
        step(0, 3, 7, 1, 1, 7, 0, 0, C_LU,  1, "lu_rt_used");
        step(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2, "idle_1");
        step(0, 5, 0, 0, 1, 5, 1, 0, C_BR,  2, "branch_over_lu");
        step(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2, "idle_2");
        step(0, 5, 0, 0, 1, 5, 1, 1, C_MST, 2, "mdu_start");
        step(0, 5, 0, 0, 1, 5, 1, 1, C_MBSY, 3, "mdu_busy3");
        step(0, 0, 0, 0, 0, 0, 0, 1, C_MBSY, 4, "mdu_busy2");
        step(0, 0, 0, 0, 0, 0, 0, 1, C_MBSY, 5, "mdu_busy1");
        step(0, 0, 0, 0, 0, 0, 0, 1, C_MEND, 6, "mdu_exit");
        step(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 7, "after_mdu");
        step(0, 5, 0, 0, 1, 5, 0, 0, C_LU,  7, "lu_at_max");
        step(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 7, "cnt_saturated");

        step(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 7, "reset_c");
        step(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, "release_c");
        step(0, 0, 0, 0, 0, 0, 0, 1, C_MST, 0, "mdu2_start");
        step(0, 0, 0, 0, 0, 0, 0, 1, C_MBSY, 1, "mdu2_busy1");
        step(1, 0, 0, 0, 0, 0, 0, 1, C_RST, 2, "mdu2_abort");
        step(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, "after_abort");

        for (int i = 0; i < 9; i++)
            step(0, 9, 0, 0, 1, 9, 0, 0, C_LU, (i > 7) ? 3'd7 : 3'(i), "lu_run");
        step(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 7, "nine_stalls");

        repeat (4) @(posedge clk);
        checks++;
        if (sb.size() == 0)
            passes++;
        else
            $display("FAIL drain: %0d entries left, expected 0", sb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
